// File: rtl/order_executed_with_price_encoder_pkg.sv
// Shared constants and keep-mask helpers for the ITCH "Order Executed With Price"
// encoder and parsers.
package order_executed_with_price_encoder_pkg;

    localparam int BODY_BYTES = 51;
    localparam int DATA_W     = 64;
    localparam int KEEP_W     = DATA_W / 8;
    localparam int BODY_W     = BODY_BYTES * 8;
    localparam int BUF_W      = BODY_W + DATA_W;

    localparam int TIME_STAMP_W        = 32;
    localparam int ORDER_ID_W          = 64;
    localparam int ORDER_BOOK_ID_W     = 32;
    localparam int SIDE_W              = 8;
    localparam int EXECUTED_QUANTITY_W = 64;
    localparam int MATCH_ID_W          = 64;
    localparam int COMBO_GROUP_ID_W    = 32;
    localparam int RESERVED_ONE_W      = 32;
    localparam int RESERVED_TWO_W      = 32;
    localparam int TRADE_PRICE_W       = 32;
    localparam int OCCURED_AT_CROSS_W  = 8;
    localparam int PRINTABLE_W         = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } enc_state_e;

    // Bytes at and above the given byte offset are valid.
    function automatic logic [KEEP_W-1:0] keep_from_offset(input logic [2:0] off);
        return 8'hFF << off;
    endfunction

    // Bytes below the given count are valid; a count of zero means a full word.
    function automatic logic [KEEP_W-1:0] keep_below(input logic [2:0] cnt);
        return (cnt == 3'd0) ? 8'hFF : ((8'h01 << cnt) - 8'h01);
    endfunction

endpackage

// File: rtl/order_executed_with_price_encoder.sv
// Serializes one "Order Executed With Price" body onto a 64-bit little-endian
// word stream starting at an arbitrary byte offset in the first word.
module order_executed_with_price_encoder
    import order_executed_with_price_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        startIn,
    output logic        startReady,
    input  logic [5:0]  trackerIn,
    input  logic [31:0] timeStamp,
    input  logic [63:0] orderID,
    input  logic [31:0] orderBookID,
    input  logic [7:0]  side,
    input  logic [63:0] executedQuantity,
    input  logic [63:0] matchID,
    input  logic [31:0] comboGroupID,
    input  logic [31:0] reservedOne,
    input  logic [31:0] reservedTwo,
    input  logic [31:0] tradePrice,
    input  logic [7:0]  occuredAtCross,
    input  logic [7:0]  printable,
    output logic [63:0] dataOut,
    output logic [7:0]  dataKeep,
    output logic        dataValid,
    input  logic        dataReady,
    output logic        dataLast,
    output logic [5:0]  trackerOut,
    output logic        signal_end
);

    enc_state_e         state_q;
    logic [BUF_W-1:0]   buf_q;
    logic [2:0]         cnt_q;
    logic [2:0]         last_idx_q;
    logic [KEEP_W-1:0]  last_keep_q;
    logic [5:0]         last_trk_q;
    logic [DATA_W-1:0]  data_q;
    logic [KEEP_W-1:0]  keep_q;
    logic               valid_q;
    logic               last_q;
    logic [5:0]         trk_q;
    logic               end_q;

    logic [2:0]         off_d;
    logic [2:0]         rem_d;
    logic [BODY_W-1:0]  body_d;
    logic [BUF_W-1:0]   shifted_d;

    assign off_d  = 3'(trackerIn >> 3);
    // (off + 51) mod 8 reduces to (off + 3) mod 8
    assign rem_d  = off_d + 3'd3;
    assign body_d = {printable, occuredAtCross, tradePrice, reservedTwo, reservedOne,
                     comboGroupID, matchID, executedQuantity, side, orderBookID,
                     orderID, timeStamp};
    assign shifted_d = BUF_W'(body_d) << {off_d, 3'b000};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            buf_q       <= '0;
            cnt_q       <= '0;
            last_idx_q  <= '0;
            last_keep_q <= '0;
            last_trk_q  <= '0;
            data_q      <= '0;
            keep_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            trk_q       <= '0;
            end_q       <= 1'b0;
        end else begin
            end_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (startIn) begin
                        data_q      <= shifted_d[DATA_W-1:0];
                        buf_q       <= shifted_d >> DATA_W;
                        keep_q      <= keep_from_offset(off_d);
                        valid_q     <= 1'b1;
                        last_q      <= 1'b0;
                        trk_q       <= '0;
                        cnt_q       <= '0;
                        last_idx_q  <= (off_d >= 3'd6) ? 3'd7 : 3'd6;
                        last_keep_q <= keep_below(rem_d);
                        last_trk_q  <= {rem_d, 3'b000};
                        state_q     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (valid_q && dataReady) begin
                        if (cnt_q == last_idx_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            data_q  <= '0;
                            keep_q  <= '0;
                            trk_q   <= '0;
                            end_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q  <= cnt_q + 3'd1;
                            data_q <= buf_q[DATA_W-1:0];
                            buf_q  <= buf_q >> DATA_W;
                            if (cnt_q + 3'd1 == last_idx_q) begin
                                keep_q <= last_keep_q;
                                last_q <= 1'b1;
                                trk_q  <= last_trk_q;
                            end else begin
                                keep_q <= 8'hFF;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign startReady = rst && (state_q == ST_IDLE);
    assign dataOut    = data_q;
    assign dataKeep   = keep_q;
    assign dataValid  = valid_q;
    assign dataLast   = last_q;
    assign trackerOut = trk_q;
    assign signal_end = end_q;

endmodule

// File: doc/order_executed_with_price_encoder.md
Name: order_executed_with_price_encoder

Overview:
- Transmit-side counterpart of the ITCH "Order Executed With Price" body parser.
- Accepts one complete set of decoded message fields and serializes the 51-byte message body (timestamp through printable) onto a 64-bit little-endian word stream.
- The body starts at a byte offset given by the upstream message-type/framing stage.
- Reports where the next message begins in the final word, using the same tracker convention the parsers consume.

Parameters:
- BODY_BYTES, 51, message body length in bytes (fixed by protocol; not meant to be overridden)
- DATA_W, 64, stream word width in bits

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-low reset
- startIn  in  1  request to encode; fields and trackerIn sampled when startIn && startReady
- startReady  out  1  high in IDLE when rst is deasserted
- trackerIn  in  6  bit offset of first body byte in first word; multiple of 8; bits [2:0] ignored
- timeStamp  in  32  field
- orderID  in  64  field
- orderBookID  in  32  field
- side  in  8  field
- executedQuantity  in  64  field
- matchID  in  64  field
- comboGroupID  in  32  field
- reservedOne  in  32  field
- reservedTwo  in  32  field
- tradePrice  in  32  field
- occuredAtCross  in  8  field
- printable  in  8  field
- dataOut  out  64  stream word
- dataKeep  out  8  byte-valid mask, bit i covers dataOut[8i+7:8i]
- dataValid  out  1  word valid
- dataReady  in  1  downstream accept
- dataLast  out  1  marks final word of message
- trackerOut  out  6  bit offset of first free byte in last word; valid while dataLast
- signal_end  out  1  one-cycle pulse on the cycle the last word handshakes

Behaviour:
- Body byte order, LSB first: timeStamp, orderID, orderBookID, side, executedQuantity, matchID, comboGroupID, reservedOne, reservedTwo, tradePrice, occuredAtCross, printable. Each field is little-endian. Total 408 bits.
- Reset (rst=0 at a posedge): state IDLE; all registered outputs 0 (dataOut, dataKeep, dataValid, dataLast, trackerOut, signal_end). Any message in flight is discarded with no further words emitted. startReady is 0 while rst=0.
- States:
  - IDLE: startReady=1. On startIn, latch {fields} into a 408-bit buffer.
    - off = trackerIn[5:3].
    - wordsTotal = ceil((off+51)/8), which is 7 for off 0..5 and 8 for off 6..7.
    - Go to SEND. The first word is valid on the next cycle (1-cycle latency).
  - SEND: word k carries bytes of (body << 8*off) at [64k+63:64k].
    - Word 0: dataKeep = 8'hFF << off.
    - Middle words: 8'hFF.
    - Last word: dataKeep = (1 << r) - 1, where r = (off+51) mod 8. If r = 0, use 8'hFF.
    - Unkept bytes are driven 0.
    - dataLast is set on word wordsTotal-1. trackerOut = 8*r, which is 0 when r = 0.
  - Advance on dataValid && dataReady only. While dataReady=0, dataOut/dataKeep/dataLast stay stable.
  - On the last-word handshake: pulse signal_end, drop dataValid, return to IDLE.
- Boundary rules:
  - startIn while not IDLE is ignored; there is no queueing.
  - Back-to-back messages have one idle cycle minimum between them.
  - trackerIn bits [2:0] nonzero: ignored, no error.
  - The word counter is 3 bits; wordsTotal=8 uses counter values 0..7, with no wrap ambiguity because completion is compared against wordsTotal-1.

Decomposition:
- Shared package: BODY_BYTES, field width constants, and a byte-offset-to-keep-mask function (usable by the parsers).
- No sub-module. A single FSM plus shift buffer is natural.
- The buffer shift may be a barrel shift at latch time (the 472-bit buffer is pre-shifted) followed by a 64-bit right-shift per accepted word.

Test Plan:
1. trackerIn=0, timeStamp=32'h11223344, orderID=64'h0102030405060708, all else 0, dataReady=1 -> 7 words. Word0 = 64'h05060708_11223344, keep 8'hFF. Word6 keep 8'h07, dataLast=1, trackerOut=24, signal_end pulse.
2. trackerIn=40 (off 5) -> exactly 7 words. Word0 keep 8'hE0 and timeStamp in bytes 5..7. Last keep 8'hFF, trackerOut=0.
3. trackerIn=56 (off 7) -> 8 words. Word0 keep 8'h80. Last keep 8'h03 holding occuredAtCross, printable. trackerOut=16.
4. Case 1 with dataReady toggling 1,0,0,1,... -> words are held stable while stalled. Identical word sequence to case 1; signal_end pulses exactly once.
5. startIn pulsed again in word 3 with different fields -> ignored. Output equals first message; startReady=0 until IDLE.
6. rst=0 during word 4 -> next cycle dataValid=0 and all outputs 0. New start after release encodes cleanly from word 0.
